// File: rtl/pipe_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_pkg                                                |
// | Description : Shared types and constants for the pipeline sequencer.       |
// |               The state enum and PC-source encodings are also used by the  |
// |               PC mux and the hazard-unit bench.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    RST_HOLD  = 2'd0,
    RUN       = 2'd1,
    MD_WAIT   = 2'd2,
    EXC_FLUSH = 2'd3
  } pc_state_e;

  // PC mux source select
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_EXC = 2'b10;

  // One complete set of stage controls.
  typedef struct packed {
    logic       pc_ena;
    logic [1:0] pc_sel;
    logic       if_id_ena;
    logic       id_ex_ena;
    logic       ex_mem_ena;
    logic       mem_wb_ena;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
  } stage_ctrl_t;

  // Everything frozen, every register bubbled.
  localparam stage_ctrl_t CTRL_RESET = '{
    pc_ena: 1'b0, pc_sel: PC_SEL_SEQ,
    if_id_ena: 1'b0, id_ex_ena: 1'b0, ex_mem_ena: 1'b0, mem_wb_ena: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};

  // Free-running pipeline.
  localparam stage_ctrl_t CTRL_RUN = '{
    pc_ena: 1'b1, pc_sel: PC_SEL_SEQ,
    if_id_ena: 1'b1, id_ex_ena: 1'b1, ex_mem_ena: 1'b1, mem_wb_ena: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

  // Load/use stall: hold PC and IF/ID, bubble into ID/EX, back end drains.
  localparam stage_ctrl_t CTRL_STALL = '{
    pc_ena: 1'b0, pc_sel: PC_SEL_SEQ,
    if_id_ena: 1'b0, id_ex_ena: 1'b1, ex_mem_ena: 1'b1, mem_wb_ena: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

  // Taken branch: redirect PC, squash the wrong-path fetch in IF/ID.
  localparam stage_ctrl_t CTRL_BRANCH = '{
    pc_ena: 1'b1, pc_sel: PC_SEL_BR,
    if_id_ena: 1'b1, id_ex_ena: 1'b1, ex_mem_ena: 1'b1, mem_wb_ena: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

  // Mul/div occupies EX: front end frozen, bubbles flow out of EX so that
  // older instructions in MEM/WB still complete.
  localparam stage_ctrl_t CTRL_MD_FREEZE = '{
    pc_ena: 1'b0, pc_sel: PC_SEL_SEQ,
    if_id_ena: 1'b0, id_ex_ena: 1'b0, ex_mem_ena: 1'b1, mem_wb_ena: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};

  // Exception taken: jump to the vector, kill everything younger than MEM,
  // and keep the faulting instruction out of WB.
  localparam stage_ctrl_t CTRL_EXC = '{
    pc_ena: 1'b1, pc_sel: PC_SEL_EXC,
    if_id_ena: 1'b1, id_ex_ena: 1'b1, ex_mem_ena: 1'b1, mem_wb_ena: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};

  // Cycle after the redirect: the vector instruction moves into ID while the
  // back end still carries bubbles.
  localparam stage_ctrl_t CTRL_EXC_FLUSH = '{
    pc_ena: 1'b1, pc_sel: PC_SEL_SEQ,
    if_id_ena: 1'b1, id_ex_ena: 1'b1, ex_mem_ena: 1'b1, mem_wb_ena: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};

  // Normal-advance controls: a stall outranks a branch because the branch
  // operands are not ready yet; the branch is presented again afterwards.
  function automatic stage_ctrl_t ctrl_advance(input logic hz_stall,
                                               input logic branch_taken);
    stage_ctrl_t c;
    c = CTRL_RUN;
    if (hz_stall) begin
      c = CTRL_STALL;
    end else if (branch_taken) begin
      c = CTRL_BRANCH;
    end
    return c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  // Down-counter width able to hold the largest load value.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_if                                                 |
// | Description : Request/control bundle between the pipeline sequencer and   |
// |               the datapath.                                                |
// |   Requests  : hz_stall_i, branch_taken_i, md_start_i, md_div_i, exc_i     |
// |   Controls  : pc_ena_o, pc_sel_o[1:0], *_ena_o, *_flush_o,                |
// |               md_busy_o, md_done_o, md_abort_o                             |
// |   master    : the sequencer (consumes requests, drives controls)          |
// |   slave     : the datapath side (drives requests, consumes controls)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_ctrl_if;

  // Requests from the datapath / hazard unit
  logic       hz_stall_i;
  logic       branch_taken_i;
  logic       md_start_i;
  logic       md_div_i;
  logic       exc_i;

  // Controls back to the datapath
  logic       pc_ena_o;
  logic [1:0] pc_sel_o;
  logic       if_id_ena_o;
  logic       id_ex_ena_o;
  logic       ex_mem_ena_o;
  logic       mem_wb_ena_o;
  logic       if_id_flush_o;
  logic       id_ex_flush_o;
  logic       ex_mem_flush_o;
  logic       md_busy_o;
  logic       md_done_o;
  logic       md_abort_o;

  modport master (
    input  hz_stall_i, branch_taken_i, md_start_i, md_div_i, exc_i,
    output pc_ena_o, pc_sel_o,
           if_id_ena_o, id_ex_ena_o, ex_mem_ena_o, mem_wb_ena_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
           md_busy_o, md_done_o, md_abort_o
  );

  modport slave (
    output hz_stall_i, branch_taken_i, md_start_i, md_div_i, exc_i,
    input  pc_ena_o, pc_sel_o,
           if_id_ena_o, id_ex_ena_o, ex_mem_ena_o, mem_wb_ena_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
           md_busy_o, md_done_o, md_abort_o
  );

endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl_timer                                              |
// | Description : Loadable down-counter with zero flag. Serves both the       |
// |               post-reset hold and the mul/div occupancy wait.              |
// |   clk_i      in  clock                                                     |
// |   rst_i      in  asynchronous active-high reset (count <= RST_VAL)         |
// |   load_i     in  load load_val_i (wins over dec_i)                         |
// |   load_val_i in  value to load                                             |
// |   dec_i      in  decrement; saturates at zero                              |
// |   zero_o     out count is zero                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_ctrl_timer #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  assign zero_o = w_zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= WIDTH'(RST_VAL);
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (dec_i && !w_zero) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule : pipe_ctrl_timer
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl                                                    |
// | Description : Central sequencer for the 5-stage MIPS pipeline. Merges     |
// |               load/use stalls, ID-stage branch redirects, multi-cycle     |
// |               mul/div occupancy of EX and MEM-stage exceptions into one   |
// |               consistent set of register enables, bubble controls and a   |
// |               PC-source select.                                            |
// |   clk_i  in  clock                                                         |
// |   rst_i  in  asynchronous active-high reset                                |
// |   bus    pipe_ctrl_if.master: requests in, stage controls out              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES      = 4,
  parameter int DIV_CYCLES      = 32,
  parameter int RST_HOLD_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipe_ctrl_if.master     bus
);

  localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES, RST_HOLD_CYCLES);

  // Counter load values: the wait ends when the counter reaches zero, so an
  // N-cycle occupancy loads N-1.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  pc_state_e        r_state;
  pc_state_e        w_state_next;

  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;

  stage_ctrl_t      w_ctrl;
  logic             w_md_busy;
  logic             w_md_done;
  logic             w_md_abort;

  // --------------------------------------------------------------------------
  // Shared counter: reset value gives the post-reset freeze, a load in RUN
  // starts a mul/div wait.
  // --------------------------------------------------------------------------
  pipe_ctrl_timer #(
    .WIDTH   (CNT_W),
    .RST_VAL (RST_HOLD_CYCLES - 1)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .dec_i      (w_dec),
    .zero_o     (w_zero)
  );

  // --------------------------------------------------------------------------
  // State register. Async reset makes the reset outputs appear immediately,
  // since all outputs decode from the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RST_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, counter control and stage controls.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = MUL_LOAD;
    w_dec        = 1'b0;
    w_ctrl       = CTRL_RESET;
    w_md_busy    = 1'b0;
    w_md_done    = 1'b0;
    w_md_abort   = 1'b0;

    case (r_state)
      RST_HOLD: begin
        // Requests are ignored until the pipeline has settled.
        w_ctrl = CTRL_RESET;
        w_dec  = 1'b1;
        if (w_zero) begin
          w_state_next = RUN;
        end
      end

      RUN: begin
        if (bus.exc_i) begin
          w_ctrl       = CTRL_EXC;
          w_state_next = EXC_FLUSH;
        end else if (bus.md_start_i) begin
          w_ctrl       = CTRL_MD_FREEZE;
          w_load       = 1'b1;
          w_load_val   = bus.md_div_i ? DIV_LOAD : MUL_LOAD;
          w_state_next = MD_WAIT;
        end else begin
          w_ctrl = ctrl_advance(bus.hz_stall_i, bus.branch_taken_i);
        end
      end

      MD_WAIT: begin
        w_md_busy = 1'b1;
        w_dec     = 1'b1;
        if (bus.exc_i) begin
          // Exception kills the in-flight mul/div; no completion pulse.
          w_md_abort   = 1'b1;
          w_ctrl       = CTRL_EXC;
          w_state_next = EXC_FLUSH;
        end else if (w_zero) begin
          // Result leaves EX this cycle; the front end resumes under the
          // normal stall/branch rules. md_start_i is not a new request here.
          w_md_done    = 1'b1;
          w_ctrl       = ctrl_advance(bus.hz_stall_i, bus.branch_taken_i);
          w_state_next = RUN;
        end else begin
          w_ctrl = CTRL_MD_FREEZE;
        end
      end

      EXC_FLUSH: begin
        // exc_i is masked: stages still draining the old path must not raise
        // a second exception.
        w_ctrl       = CTRL_EXC_FLUSH;
        w_state_next = RUN;
      end

      default: begin
        w_ctrl       = CTRL_RESET;
        w_state_next = RST_HOLD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.pc_ena_o       = w_ctrl.pc_ena;
  assign bus.pc_sel_o       = w_ctrl.pc_sel;
  assign bus.if_id_ena_o    = w_ctrl.if_id_ena;
  assign bus.id_ex_ena_o    = w_ctrl.id_ex_ena;
  assign bus.ex_mem_ena_o   = w_ctrl.ex_mem_ena;
  assign bus.mem_wb_ena_o   = w_ctrl.mem_wb_ena;
  assign bus.if_id_flush_o  = w_ctrl.if_id_flush;
  assign bus.id_ex_flush_o  = w_ctrl.id_ex_flush;
  assign bus.ex_mem_flush_o = w_ctrl.ex_mem_flush;
  assign bus.md_busy_o      = w_md_busy;
  assign bus.md_done_o      = w_md_done;
  assign bus.md_abort_o     = w_md_abort;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_ctrl                                                 |
// | Description : Directed self-checking bench for pipe_ctrl                   |
// |               (MUL_CYCLES=4, DIV_CYCLES=32, RST_HOLD_CYCLES=2).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MUL_CYCLES      (4),
    .DIV_CYCLES      (32),
    .RST_HOLD_CYCLES (2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed control word, MSB first:
  // pc_ena | pc_sel[1:0] | if_id,id_ex,ex_mem,mem_wb ena | if_id,id_ex,ex_mem flush | busy,done,abort
  logic [12:0] w_obs;
  assign w_obs = {bus.pc_ena_o, bus.pc_sel_o,
                  bus.if_id_ena_o, bus.id_ex_ena_o, bus.ex_mem_ena_o, bus.mem_wb_ena_o,
                  bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_mem_flush_o,
                  bus.md_busy_o, bus.md_done_o, bus.md_abort_o};

  // Hand-derived expected control words
  localparam logic [12:0] P_RESET         = 13'b0_00_0000_111_000;
  localparam logic [12:0] P_RUN           = 13'b1_00_1111_000_000;
  localparam logic [12:0] P_STALL         = 13'b0_00_0111_010_000;
  localparam logic [12:0] P_BRANCH        = 13'b1_01_1111_100_000;
  localparam logic [12:0] P_EXC           = 13'b1_10_1110_111_000;
  localparam logic [12:0] P_EXC_MD        = 13'b1_10_1110_111_101;
  localparam logic [12:0] P_EXC_FLUSH     = 13'b1_00_1111_011_000;
  localparam logic [12:0] P_MD_START      = 13'b0_00_0011_001_000;
  localparam logic [12:0] P_MD_WAIT       = 13'b0_00_0011_001_100;
  localparam logic [12:0] P_MD_DONE       = 13'b1_00_1111_000_110;
  localparam logic [12:0] P_MD_DONE_STALL = 13'b0_00_0111_010_110;

  task automatic check(input string tag, input logic [12:0] exp);
    n_assert++;
    assert (w_obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, w_obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Apply requests, then let the combinational outputs settle.
  task automatic drive(input logic hz, input logic br, input logic ms,
                       input logic md, input logic ex);
    bus.hz_stall_i     = hz;
    bus.branch_taken_i = br;
    bus.md_start_i     = ms;
    bus.md_div_i       = md;
    bus.exc_i          = ex;
    #1;
  endtask

  initial begin
    // ---------------- reset and post-reset hold ----------------
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("reset_async", P_RESET);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("hold_1", P_RESET);
    tick();
    drive(1, 1, 1, 1, 1);
    check("hold_2_inputs_ignored", P_RESET);
    tick();
    drive(0, 0, 0, 0, 0);
    check("run_after_hold", P_RUN);

    // ---------------- single-cycle load/use stall ----------------
    tick();
    drive(1, 0, 0, 0, 0);
    check("stall", P_STALL);
    check_bit("stall_pc_ena", bus.pc_ena_o, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("stall_release", P_RUN);

    // ---------------- branch under stall, then re-presented ----------------
    tick();
    drive(1, 1, 0, 0, 0);
    check("br_under_stall", P_STALL);
    check_bit("br_under_stall_if_id_flush", bus.if_id_flush_o, 1'b0);
    tick();
    drive(0, 1, 0, 0, 0);
    check("br_represented", P_BRANCH);
    tick();
    drive(0, 0, 0, 0, 0);
    check("after_branch", P_RUN);

    // ---------------- full divide: freeze cycles 0..31, done in 32 ----------
    tick();
    drive(0, 0, 1, 1, 0);
    check("div_start", P_MD_START);
    for (int k = 1; k <= 31; k++) begin
      tick();
      drive(0, 0, (k == 1), 1, 0);  // a repeated md_start_i must be ignored
      check($sformatf("div_wait_%0d", k), P_MD_WAIT);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    check("div_done", P_MD_DONE);
    tick();
    check("div_after", P_RUN);

    // ---------------- exception mid-divide (counter = 10 in cycle 22) -------
    tick();
    drive(0, 0, 1, 1, 0);
    check("div2_start", P_MD_START);
    for (int k = 1; k <= 21; k++) begin
      tick();
      drive(0, 0, 0, 1, 0);
      check($sformatf("div2_wait_%0d", k), P_MD_WAIT);
    end
    tick();
    drive(0, 0, 0, 0, 1);
    check("div2_exc_abort", P_EXC_MD);
    check_bit("div2_exc_mem_wb_ena", bus.mem_wb_ena_o, 1'b0);
    tick();
    drive(0, 0, 0, 0, 1);
    check("exc_flush_masked", P_EXC_FLUSH);
    tick();
    drive(0, 0, 0, 0, 0);
    check("exc_to_run", P_RUN);

    // ---------------- exception from RUN ----------------
    tick();
    drive(0, 1, 1, 0, 1);  // exception outranks mul start and branch
    check("run_exc", P_EXC);
    tick();
    drive(0, 0, 0, 0, 0);
    check("run_exc_flush", P_EXC_FLUSH);
    tick();
    check("run_exc_back", P_RUN);

    // ---------------- multiply, stall arriving in the done cycle -----------
    tick();
    drive(0, 0, 1, 0, 0);
    check("mul_start", P_MD_START);
    for (int k = 1; k <= 3; k++) begin
      tick();
      drive(0, 0, 0, 0, 0);
      check($sformatf("mul_wait_%0d", k), P_MD_WAIT);
    end
    tick();
    drive(1, 0, 0, 0, 0);
    check("mul_done_stall", P_MD_DONE_STALL);
    tick();
    drive(0, 0, 0, 0, 0);
    check("mul_after", P_RUN);

    // ---------------- reset pulse during MD_WAIT ----------------
    tick();
    drive(0, 0, 1, 1, 0);
    check("div3_start", P_MD_START);
    tick();
    drive(0, 0, 0, 1, 0);
    check("div3_wait_1", P_MD_WAIT);
    rst_i = 1'b1;
    #1;
    check("rst_mid_md", P_RESET);
    tick();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("rehold_1", P_RESET);
    tick();
    check("rehold_2", P_RESET);
    tick();
    check("rerun", P_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
